// File: rtl/rr_decode_arbiter.sv
// 8-way round-robin arbiter with registered one-hot grant and hold-until-release semantics.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD consecutive grant cycles.
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout_pulse
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("MAX_HOLD out of range 2..255");
    end

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic       do_grant;
    logic [7:0] search_vec;
    logic [2:0] win;

    // Callers guarantee v != 0, so the fallback value is never used.
    function automatic logic [2:0] rr_pick(input logic [7:0] v, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       pulse_q, pulse_d;
    logic [7:0] others;

    assign others        = req & ~(8'b1 << idx_q);
    assign timeout_pulse = pulse_q;
`else
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;
        do_grant   = 1'b0;
        search_vec = req;
`ifdef ARB_TIMEOUT_EN
        hold_d     = hold_q;
        pulse_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req) do_grant = 1'b1;
            end
            StGrant: begin
                if (req[idx_q]) begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_q == HoldMax) begin
                        // Limit reached: rotate only if someone else is waiting.
                        hold_d = '0;
                        if (|others) begin
                            do_grant   = 1'b1;
                            search_vec = others;
                            pulse_d    = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end else if (|req) begin
                    do_grant = 1'b1;
                end else begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        win = rr_pick(search_vec, ptr_q);
        if (do_grant) begin
            state_d = StGrant;
            idx_d   = win;
            gnt_d   = 8'b1 << win;
            valid_d = 1'b1;
            ptr_d   = win + 3'd1;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
            pulse_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (MAX_HOLD=4); covers both builds.
module tb_rr_decode_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout_pulse;

    int n_vec = 0;
    int n_err = 0;

    rr_decode_arbiter #(
        .MAX_HOLD(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .gnt          (gnt),
        .gnt_idx      (gnt_idx),
        .gnt_valid    (gnt_valid),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_grant(input string tag, input logic [2:0] k);
        check_eq({tag, "_gnt"}, 32'(gnt), 32'(8'b1 << k));
        check_eq({tag, "_idx"}, 32'(gnt_idx), 32'(k));
        check_eq({tag, "_vld"}, 32'(gnt_valid), 32'd1);
    endtask

    initial begin
        logic [2:0] k;
        rst_n = 1'b0;
        req   = 8'h00;
        tick();
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_idx", 32'(gnt_idx), 32'h0);
        check_eq("rst_vld", 32'(gnt_valid), 32'h0);
        check_eq("rst_pulse", 32'(timeout_pulse), 32'h0);
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("idle", 32'({gnt, gnt_valid, timeout_pulse}), 32'h0);
        end

        // Single requester 2, latency one edge, idx retained after release
        req = 8'h04;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_grant("single", 3'd2);
        end
        req = 8'h00;
        tick();
        check_eq("single_rel_gnt", 32'(gnt), 32'h0);
        check_eq("single_rel_vld", 32'(gnt_valid), 32'h0);
        check_eq("single_rel_idx", 32'(gnt_idx), 32'h2);

        // Full rotation with one-cycle release pulses
        do_reset();
        req = 8'hFF;
        tick();
        for (int step = 0; step < 9; step++) begin
            k = 3'(step % 8);
            for (int c = 0; c < 3; c++) begin
                check_grant("rot", k);
                check_eq("rot_pulse", 32'(timeout_pulse), 32'h0);
                if (c < 2) tick();
            end
            req = 8'hFF & ~(8'b1 << k);
            if (step < 8) begin
                tick();
                req = 8'hFF;
            end
        end

        // Handover to 5, then 6 via req=0x41, then wrap to 0
        req = 8'h20;
        tick();
        check_grant("wrap5", 3'd5);
        req = 8'h41;
        tick();
        check_grant("wrap6", 3'd6);
        req = 8'h01;
        tick();
        check_grant("wrap0", 3'd0);
        req = 8'h00;
        tick();
        check_eq("wrap_idle", 32'(gnt_valid), 32'h0);

        // Hold limit behaviour
        do_reset();
        req = 8'h03;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("to_gnt", 32'(gnt), ((i / 4) % 2 == 1) ? 32'h2 : 32'h1);
            check_eq("to_pulse", 32'(timeout_pulse), (i % 4 == 0 && i > 0) ? 32'h1 : 32'h0);
        end
        req = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("solo_gnt", 32'(gnt), 32'h1);
            check_eq("solo_pulse", 32'(timeout_pulse), 32'h0);
        end
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("nto_gnt", 32'(gnt), 32'h1);
            check_eq("nto_pulse", 32'(timeout_pulse), 32'h0);
        end
`endif
        req = 8'h00;
        tick();

        // Asynchronous reset during grant idx 3
        do_reset();
        req = 8'h08;
        tick();
        check_grant("pre_rst", 3'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_gnt", 32'(gnt), 32'h0);
        check_eq("async_vld", 32'(gnt_valid), 32'h0);
        check_eq("async_idx", 32'(gnt_idx), 32'h0);
        tick();
        req = 8'h88;
        check_eq("held_rst_gnt", 32'(gnt), 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        check_grant("post_rst", 3'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
